program_loader: RTL and testbench

- Writer-side companion to the program memory: receives a byte stream (count header, then instruction words) and issues one-cycle word writes into program memory at byte addresses from BASE_ADDRESS.
- Sits between a byte source (debug/serial bridge) and the program memory write port.
- Holds the core in reset while loading, so it never fetches a partially written program.

---
 rtl/program_loader.sv | 173 +++++++++++++++++
 tb/tb_program_loader.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Byte-stream program loader: a little-endian word count followed by instruction words,
// written one word per cycle into program memory while the core is held in reset.
module program_loader #(
    parameter int unsigned MEMORY_DEPTH = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDRESS = 32'h0040_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Start_i,
    input  logic [7:0]            Byte_Data_i,
    input  logic                  Byte_Valid_i,
    output logic                  Byte_Ready_o,
    output logic                  Write_Enable_o,
    output logic [DATA_WIDTH-1:0] Write_Address_o,
    output logic [DATA_WIDTH-1:0] Write_Data_o,
    output logic                  Cpu_Hold_o,
    output logic                  Busy_o,
    output logic                  Done_o,
    output logic                  Error_o
);

    localparam logic [DATA_WIDTH-1:0] MaxCount = DATA_WIDTH'(MEMORY_DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StCount,
        StData,
        StWrite,
        StDone,
        StError
    } state_e;

    state_e                state_q, state_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [DATA_WIDTH-1:0] word_idx_q, word_idx_d;
    logic [DATA_WIDTH-1:0] count_q, count_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;

    logic                  ready_q, ready_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  hold_q, hold_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;

    logic                  accept;
    logic [DATA_WIDTH-1:0] full_count;
    logic [DATA_WIDTH-1:0] word_idx_inc;

    // Ready is registered, so a transfer is qualified by the registered value.
    assign accept       = Byte_Valid_i & ready_q;
    assign full_count   = {Byte_Data_i, count_q[23:0]};
    assign word_idx_inc = word_idx_q + DATA_WIDTH'(1);

    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        word_idx_d = word_idx_q;
        count_d    = count_q;
        word_d     = word_q;
        addr_d     = addr_q;
        data_d     = data_q;
        hold_d     = hold_q;
        busy_d     = busy_q;
        done_d     = done_q;
        error_d    = error_q;

        unique case (state_q)
            StIdle, StDone, StError: begin
                if (Start_i) begin
                    state_d    = StCount;
                    hold_d     = 1'b1;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    byte_idx_d = 2'd0;
                    word_idx_d = '0;
                end
            end

            StCount: begin
                if (accept) begin
                    count_d[{byte_idx_q, 3'b000} +: 8] = Byte_Data_i;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        if (full_count == '0 || full_count > MaxCount) begin
                            state_d = StError;
                            busy_d  = 1'b0;
                            error_d = 1'b1;
                        end else begin
                            state_d = StData;
                        end
                    end
                end
            end

            StData: begin
                if (accept) begin
                    word_d[{byte_idx_q, 3'b000} +: 8] = Byte_Data_i;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        state_d = StWrite;
                        addr_d  = BASE_ADDRESS + (word_idx_q << 2);
                        data_d  = {Byte_Data_i, word_q[23:0]};
                    end
                end
            end

            StWrite: begin
                if (word_idx_inc == count_q) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    hold_d  = 1'b0;
                end else begin
                    state_d    = StData;
                    word_idx_d = word_idx_inc;
                end
            end

            default: state_d = StIdle;
        endcase

        // Strobe and ready follow the state being entered so they line up with it.
        we_d    = (state_d == StWrite);
        ready_d = (state_d == StCount) || (state_d == StData);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            byte_idx_q <= 2'd0;
            word_idx_q <= '0;
            count_q    <= '0;
            word_q     <= '0;
            ready_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            hold_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            word_idx_q <= word_idx_d;
            count_q    <= count_d;
            word_q     <= word_d;
            ready_q    <= ready_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            hold_q     <= hold_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign Byte_Ready_o    = ready_q;
    assign Write_Enable_o  = we_q;
    assign Write_Address_o = addr_q;
    assign Write_Data_o    = data_q;
    assign Cpu_Hold_o      = hold_q;
    assign Busy_o          = busy_q;
    assign Done_o          = done_q;
    assign Error_o         = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected writes are queued as words are sent and
// checked by a monitor whenever the write strobe is seen.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        Start_i = 1'b0;
    logic [7:0]  Byte_Data_i = 8'h00;
    logic        Byte_Valid_i = 1'b0;
    logic        Byte_Ready_o;
    logic        Write_Enable_o;
    logic [31:0] Write_Address_o;
    logic [31:0] Write_Data_o;
    logic        Cpu_Hold_o;
    logic        Busy_o;
    logic        Done_o;
    logic        Error_o;

    program_loader dut (
        .clk            (clk),
        .reset          (reset),
        .Start_i        (Start_i),
        .Byte_Data_i    (Byte_Data_i),
        .Byte_Valid_i   (Byte_Valid_i),
        .Byte_Ready_o   (Byte_Ready_o),
        .Write_Enable_o (Write_Enable_o),
        .Write_Address_o(Write_Address_o),
        .Write_Data_o   (Write_Data_o),
        .Cpu_Hold_o     (Cpu_Hold_o),
        .Busy_o         (Busy_o),
        .Done_o         (Done_o),
        .Error_o        (Error_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    localparam logic [31:0] Base = 32'h0040_0000;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          elapsed = 0;
    int          nwrites = 0;
    logic [31:0] last_addr = '0;
    wr_t         exp_q[$];
    logic [31:0] wbuf[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor: every strobe must match the head of the expected queue.
    always @(negedge clk) begin
        wr_t e;
        if (Write_Enable_o) begin
            nwrites++;
            last_addr = Write_Address_o;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr=%h data=%h, none expected",
                         Write_Address_o, Write_Data_o);
            end else begin
                e = exp_q.pop_front();
                if (Write_Address_o !== e.a || Write_Data_o !== e.d) begin
                    errors++;
                    $display("FAIL write: got addr=%h data=%h, expected addr=%h data=%h",
                             Write_Address_o, Write_Data_o, e.a, e.d);
                end
            end
        end
    end

    task automatic start_load();
        @(negedge clk);
        Start_i = 1'b1;
        @(negedge clk);
        Start_i = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int n;
        n = 0;
        Byte_Data_i  = b;
        Byte_Valid_i = 1'b1;
        while (!Byte_Ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: ready=%b after %0d cycles, expected 1", Byte_Ready_o, n);
        end
        @(negedge clk);
        if (gap) begin
            Byte_Valid_i = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8], gap);
        end
    endtask

    task automatic wait_not_busy();
        int k;
        k = 0;
        while (Busy_o && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (k >= 500) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout: busy=%b, expected 0", Busy_o);
        end
        elapsed = cyc - start_cyc;
    endtask

    // Sends count then the words in wbuf; expected writes are pushed only if count is legal.
    task automatic do_load(input logic [31:0] count, input bit ok, input bit gap);
        wr_t e;
        start_load();
        send_word(count, gap);
        if (ok) begin
            for (int i = 0; i < wbuf.size(); i++) begin
                e.a = Base + 32'(i) * 32'd4;
                e.d = wbuf[i];
                exp_q.push_back(e);
                send_word(wbuf[i], gap);
            end
        end
        Byte_Valid_i = 1'b0;
        wait_not_busy();
        @(negedge clk);
    endtask

    task automatic check_flags(input string name, input logic done, input logic err,
                               input logic hold);
        checks++;
        if (Done_o !== done || Error_o !== err || Cpu_Hold_o !== hold || Busy_o !== 1'b0) begin
            errors++;
            $display("FAIL %s flags: done=%b err=%b hold=%b busy=%b, expected %b %b %b 0",
                     name, Done_o, Error_o, Cpu_Hold_o, Busy_o, done, err, hold);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s pending: %0d writes missing, expected 0", name, exp_q.size());
        end
    endtask

    task automatic check_outputs_zero(input string name);
        checks++;
        if ({Byte_Ready_o, Write_Enable_o, Cpu_Hold_o, Busy_o, Done_o, Error_o} !== 6'b0 ||
            Write_Address_o !== 32'h0 || Write_Data_o !== 32'h0) begin
            errors++;
            $display("FAIL %s: rdy=%b we=%b hold=%b busy=%b done=%b err=%b addr=%h data=%h, all 0",
                     name, Byte_Ready_o, Write_Enable_o, Cpu_Hold_o, Busy_o, Done_o, Error_o,
                     Write_Address_o, Write_Data_o);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        check_outputs_zero("reset_hold");
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_outputs_zero("reset_release");
    endtask

    task automatic test_two_word();
        wbuf = '{32'h0010_0513, 32'h0020_0593};
        do_load(32'd2, 1'b1, 1'b0);
        check_flags("two_word", 1'b1, 1'b0, 1'b0);
        checks++;
        if (elapsed != 14) begin
            errors++;
            $display("FAIL two_word_latency: busy low after %0d cycles, expected 14", elapsed);
        end
    endtask

    task automatic test_bad_counts();
        int w0;
        w0 = nwrites;
        wbuf = '{32'hDEAD_BEEF};
        do_load(32'd0, 1'b0, 1'b0);
        check_flags("count_zero", 1'b0, 1'b1, 1'b1);
        checks++;
        if (elapsed != 4) begin
            errors++;
            $display("FAIL count_zero_latency: busy low after %0d cycles, expected 4", elapsed);
        end
        do_load(32'd33, 1'b0, 1'b0);
        check_flags("count_33", 1'b0, 1'b1, 1'b1);
        checks++;
        if (nwrites != w0) begin
            errors++;
            $display("FAIL bad_count_writes: %0d writes, expected 0", nwrites - w0);
        end
        wbuf = '{32'h1234_5678};
        do_load(32'd1, 1'b1, 1'b0);
        check_flags("after_error", 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_stalls();
        int w0;
        w0 = nwrites;
        wbuf = '{32'hCAFE_F00D};
        do_load(32'd1, 1'b1, 1'b1);
        check_flags("stall", 1'b1, 1'b0, 1'b0);
        checks++;
        if (elapsed != 16 || nwrites - w0 != 1) begin
            errors++;
            $display("FAIL stall: busy low after %0d cycles with %0d writes, expected 16 and 1",
                     elapsed, nwrites - w0);
        end
    endtask

    task automatic test_start_during_data();
        wr_t e;
        int  w0;
        w0 = nwrites;
        start_load();
        send_word(32'd2, 1'b0);
        e.a = Base;
        e.d = 32'hA1B2_C3D4;
        exp_q.push_back(e);
        send_byte(8'hD4, 1'b0);
        send_byte(8'hC3, 1'b0);
        Start_i = 1'b1;
        send_byte(8'hB2, 1'b0);
        Start_i = 1'b0;
        send_byte(8'hA1, 1'b0);
        e.a = Base + 32'd4;
        e.d = 32'h0BAD_F00D;
        exp_q.push_back(e);
        send_word(32'h0BAD_F00D, 1'b0);
        Byte_Valid_i = 1'b0;
        wait_not_busy();
        @(negedge clk);
        check_flags("start_in_data", 1'b1, 1'b0, 1'b0);
        checks++;
        if (nwrites - w0 != 2 || elapsed != 14) begin
            errors++;
            $display("FAIL start_in_data: %0d writes in %0d cycles, expected 2 in 14",
                     nwrites - w0, elapsed);
        end
    endtask

    task automatic test_reset_mid_load();
        start_load();
        send_word(32'd1, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        #2 reset = 1'b0;
        #1 check_outputs_zero("reset_async");
        Byte_Valid_i = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_outputs_zero("reset_mid_release");
        wbuf = '{32'h7777_0001};
        do_load(32'd1, 1'b1, 1'b0);
        check_flags("after_reset", 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_full_depth();
        int w0;
        w0 = nwrites;
        wbuf.delete();
        for (int i = 0; i < 32; i++) begin
            wbuf.push_back($urandom);
        end
        do_load(32'd32, 1'b1, 1'b0);
        check_flags("full_depth", 1'b1, 1'b0, 1'b0);
        checks++;
        if (last_addr !== 32'h0040_007C || nwrites - w0 != 32 || elapsed != 164) begin
            errors++;
            $display("FAIL full_depth: last=%h writes=%0d cycles=%0d, expected 0040007c 32 164",
                     last_addr, nwrites - w0, elapsed);
        end
    endtask

    initial begin
        test_reset();
        test_two_word();
        test_bad_counts();
        test_stalls();
        test_start_during_data();
        test_reset_mid_load();
        test_full_depth();
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
